alu_seq: RTL and testbench

Parametrised, handshaked successor to the 5-bit combinational ALU. It adds a configurable operand width, registered results with status flags, an accumulator operand mode, a variable-distance shift, and a multi-cycle shift-add multiplier. It sits between the operand-capture logic and the result/LED output stage, and accepts one operation at a time through a valid/ready handshake.

---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered flags, accumulator and shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_acc,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_o;
  logic               alu_err;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mul_lo;
  logic               mul_hi_nz;

  assign in_ready = (state == S_IDLE);
  assign shamt    = b[SHW-1:0];

  // Operand A source: a same-cycle acc_clr makes the accumulator read as zero
  always_comb begin
    op_a = use_acc ? (acc_clr ? '0 : acc) : a;
  end

  // Single-cycle datapath evaluated on the accept cycle's inputs
  always_comb begin
    add_w   = {1'b0, op_a} + {1'b0, b};
    sub_w   = {1'b0, op_a} - {1'b0, b};
    shl_w   = {1'b0, op_a} << shamt;
    shr_w   = {op_a, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_o   = (op_a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_o   = (op_a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & b;
      OP_OR:  alu_res = op_a | b;
      OP_XOR: alu_res = op_a ^ b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        // bit WIDTH of the widened shift holds the last bit pushed out
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        // bit 0 of the widened shift holds the last bit pushed out
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Next partial product: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    prod_next = prod + (mplier[0] ? mcand : '0);
    mul_lo    = prod_next[WIDTH-1:0];
    mul_hi_nz = |prod_next[2*WIDTH-1:WIDTH];
  end

  // Control FSM, result/flag registers, multiplier state and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state  <= S_BUSY;
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, op_a};
              mplier <= b;
              cnt    <= '0;
              if (acc_clr) acc <= '0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              carry     <= alu_c;
              ovf       <= alu_o;
              zero      <= (alu_res == '0);
              neg       <= alu_res[WIDTH-1];
              err       <= alu_err;
              // result load beats acc_clr; illegal ops leave acc alone
              if (!alu_err)    acc <= alu_res;
              else if (acc_clr) acc <= '0;
            end
          end else if (acc_clr) begin
            acc <= '0;
          end
        end
        S_BUSY: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= mul_lo;
            carry     <= mul_hi_nz;
            ovf       <= mul_hi_nz;
            zero      <= (mul_lo == '0);
            neg       <= mul_lo[WIDTH-1];
            err       <= 1'b0;
            acc       <= mul_lo;
          end else if (acc_clr) begin
            acc <= '0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
          if (acc_clr) acc <= '0;
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed-vector bench for alu_seq
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic       use_acc;
  logic       acc_clr;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       ovf;
  logic       zero;
  logic       neg;
  logic       err;
  logic [7:0] acc;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .use_acc  (use_acc),
    .acc_clr  (acc_clr),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .err      (err),
    .acc      (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {carry, ovf, zero, neg, err}
  task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic ua, input logic clr, input int hold,
                        input logic [7:0] er, input logic ec, input logic eo, input logic ee,
                        input logic [7:0] eacc, input int elat);
    int lat;
    logic [4:0] eflags;
    eflags    = {ec, eo, (er == 8'h00), er[7], ee};
    out_ready = 1'b0;
    op        = o;
    a         = av;
    b         = bv;
    use_acc   = ua;
    acc_clr   = clr;
    in_valid  = 1'b1;
    check({tag, "_rdy_before"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    use_acc  = 1'b0;
    acc_clr  = 1'b0;
    if (elat > 1) check({tag, "_busy_rdy"}, in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, {carry, ovf, zero, neg, err}, eflags);
    check({tag, "_acc"}, acc, eacc);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_res"}, result, er);
      check({tag, "_hold_rdy"}, in_ready, 1'b0);
      check({tag, "_hold_vld"}, out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, out_valid, 1'b0);
    check({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    use_acc   = 1'b0;
    acc_clr   = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_rdy", in_ready, 1'b1);
    check("rst_vld", out_valid, 1'b0);
    check("rst_res", result, 8'h00);
    check("rst_flags", {carry, ovf, zero, neg, err}, 5'b00000);
    check("rst_acc", acc, 8'h00);

    //      tag      op     a      b      ua    clr  hold  res    c     o     e     acc    lat
    run_op("add_ovf", 4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1);
    run_op("sub_bw",  4'd1, 8'h03, 8'h05, 1'b0, 1'b0, 0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE, 1);
    run_op("sub_z",   4'd1, 8'h05, 8'h05, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1);
    run_op("add_c",   4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1);
    run_op("mul",     4'd8, 8'h10, 8'h11, 1'b0, 1'b0, 0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10, 9);
    run_op("mul_sm",  4'd8, 8'h0D, 8'h0B, 1'b0, 1'b0, 0, 8'h8F, 1'b0, 1'b0, 1'b0, 8'h8F, 9);

    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("acc_clr", acc, 8'h00);

    run_op("acc1",    4'd0, 8'hAA, 8'h05, 1'b1, 1'b0, 0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 1);
    run_op("acc2",    4'd0, 8'hAA, 8'h05, 1'b1, 1'b0, 4, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h0A, 1);
    run_op("acc3",    4'd0, 8'hAA, 8'h05, 1'b1, 1'b0, 0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F, 1);
    run_op("shl",     4'd6, 8'h81, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h02, 1);
    run_op("shr0",    4'd7, 8'hB4, 8'h00, 1'b0, 1'b0, 0, 8'hB4, 1'b0, 1'b0, 1'b0, 8'hB4, 1);
    run_op("shr3",    4'd7, 8'h85, 8'h03, 1'b0, 1'b0, 0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h10, 1);
    run_op("xor",     4'd4, 8'hF0, 8'hFF, 1'b0, 1'b0, 0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F, 1);
    run_op("not",     4'd5, 8'h0F, 8'h33, 1'b0, 1'b0, 0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 1);
    run_op("and",     4'd2, 8'hC3, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1);
    run_op("or",      4'd3, 8'hC0, 8'h0C, 1'b0, 1'b0, 0, 8'hCC, 1'b0, 1'b0, 1'b0, 8'hCC, 1);
    run_op("illegal", 4'd12, 8'h01, 8'h02, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hCC, 1);
    run_op("clr_acc", 4'd0, 8'h77, 8'h03, 1'b1, 1'b1, 0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03, 1);

    // abort a multiply in its fourth BUSY cycle
    op       = 4'd8;
    a        = 8'h03;
    b        = 8'h05;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("abort_busy", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rdy", in_ready, 1'b1);
    check("abort_vld", out_valid, 1'b0);
    check("abort_res", result, 8'h00);
    check("abort_acc", acc, 8'h00);
    step();
    check("abort_stay", out_valid, 1'b0);

    run_op("post_rst", 4'd0, 8'h02, 8'h02, 1'b0, 1'b0, 0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
